unary_dot_accum: RTL and testbench

Downstream stage of the unary multiply array. It consumes the per-cycle popcount (tree_sum) produced by the adder tree over all product-block unary outputs, plus the per-lane done flags. It integrates the popcount into a binary dot-product across one compute window, detects window completion, and presents the result on a valid/ready output handshake. A timeout watchdog and an overrun flag are included for bring-up.

---
 rtl/unary_dot_pkg.sv | 29 ++
 rtl/unary_dot_accum_sat_accum.sv | 50 +++++
 rtl/unary_dot_accum.sv | 104 ++++++++++
 tb/tb_unary_dot_accum.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/unary_dot_pkg.sv
// Shared types and helpers for the unary dot-product accumulator stage.
// Holds the window FSM encoding, the default sizing and the saturating add.
package unary_dot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ACCUM = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int NUM_PRODS = 16;
    localparam int WIDTH     = 4;
    localparam int TREE_W    = $clog2(NUM_PRODS + 1);
    localparam int ACC_W     = 2 * WIDTH + $clog2(NUM_PRODS);

    // Returns {carry, value}; on carry-out the value pins to all-ones.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  acc,
                                               input logic [TREE_W-1:0] inc);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W + 1 - TREE_W){1'b0}}, inc};
        if (sum[ACC_W]) begin
            sat_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

// File: rtl/unary_dot_accum_sat_accum.sv
// Saturating accumulator: integrates the per-cycle popcount and keeps a
// sticky saturation flag until the next clear.
module sat_accum
    import unary_dot_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [TREE_W-1:0] inc_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              sat_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [ACC_W:0]   add_s;

    // Next-state: clear wins over accumulate, otherwise hold.
    always_comb begin
        add_s = sat_add(acc_q, inc_i);
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr_i) begin
            acc_d = {ACC_W{1'b0}};
            sat_d = 1'b0;
        end else if (en_i) begin
            acc_d = add_s[ACC_W-1:0];
            sat_d = sat_q | add_s[ACC_W];
        end else begin
            acc_d = acc_q;
            sat_d = sat_q;
        end
    end

    // Accumulator and saturation flag registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= {ACC_W{1'b0}};
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc_o = acc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/unary_dot_accum.sv
// Window controller for the unary dot product: arms on start, integrates the
// adder-tree popcount until all lanes finish or the watchdog fires, then holds.
module unary_dot_accum
    import unary_dot_pkg::*;
#(
    parameter int CNT_W      = 10,
    parameter int MAX_CYCLES = 1000
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [TREE_W-1:0]    tree_sum_i,
    input  logic [NUM_PRODS-1:0] prod_done_i,
    input  logic                 out_ready_i,
    output logic                 out_valid_o,
    output logic [ACC_W-1:0]     out_sum_o,
    output logic [CNT_W-1:0]     out_cycles_o,
    output logic                 out_sat_o,
    output logic                 out_timeout_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             overrun_q;
    logic             all_done_s;
    logic             acc_clr_s;
    logic             acc_en_s;

    assign all_done_s = &prod_done_i;
    // A new window opens from IDLE, or straight out of HOLD on the accepting cycle.
    assign acc_clr_s  = start_i & ((state_q == IDLE) | ((state_q == HOLD) & out_ready_i));
    assign acc_en_s   = (state_q == ARM) | (state_q == ACCUM);

    sat_accum u_sat_accum (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (acc_clr_s),
        .en_i    (acc_en_s),
        .inc_i   (tree_sum_i),
        .acc_o   (out_sum_o),
        .sat_o   (out_sat_o)
    );

    // Window FSM, ACCUM-cycle counter, watchdog and sticky overrun flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= ARM;
                        cnt_q     <= {CNT_W{1'b0}};
                        timeout_q <= 1'b0;
                    end
                end
                ARM: begin
                    // Lanes still show the previous window's done flags here.
                    state_q <= ACCUM;
                    if (start_i) overrun_q <= 1'b1;
                end
                ACCUM: begin
                    cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (start_i) overrun_q <= 1'b1;
                    if (all_done_s) begin
                        state_q <= HOLD;
                    end else if (cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                        state_q   <= HOLD;
                        timeout_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        if (start_i) begin
                            state_q   <= ARM;
                            cnt_q     <= {CNT_W{1'b0}};
                            timeout_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (start_i) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid_o   = (state_q == HOLD);
    assign busy_o        = (state_q == ARM) | (state_q == ACCUM);
    assign out_cycles_o  = cnt_q;
    assign out_timeout_o = timeout_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_unary_dot_accum.sv
// Directed plus randomized bench for unary_dot_accum with a window-level
// reference model (sum of presented popcounts, clipped at the accumulator max).
module tb_unary_dot_accum;
    import unary_dot_pkg::*;

    localparam int CNT_W   = 10;
    localparam int MAXC    = 1000;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic                 clk_i = 1'b0;
    logic                 reset_i;
    logic                 start_i;
    logic [TREE_W-1:0]    tree_sum_i;
    logic [NUM_PRODS-1:0] prod_done_i;
    logic                 out_ready_i;
    logic                 out_valid_o;
    logic [ACC_W-1:0]     out_sum_o;
    logic [CNT_W-1:0]     out_cycles_o;
    logic                 out_sat_o;
    logic                 out_timeout_o;
    logic                 busy_o;
    logic                 overrun_o;

    int errors = 0;
    int checks = 0;

    unary_dot_accum #(.CNT_W(CNT_W), .MAX_CYCLES(MAXC)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .tree_sum_i    (tree_sum_i),
        .prod_done_i   (prod_done_i),
        .out_ready_i   (out_ready_i),
        .out_valid_o   (out_valid_o),
        .out_sum_o     (out_sum_o),
        .out_cycles_o  (out_cycles_o),
        .out_sat_o     (out_sat_o),
        .out_timeout_o (out_timeout_o),
        .busy_o        (busy_o),
        .overrun_o     (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int mode);
        return (mode >= 0) ? mode : int'($urandom_range(0, NUM_PRODS));
    endfunction

    function automatic logic [NUM_PRODS-1:0] not_all();
        logic [NUM_PRODS-1:0] r;
        r = NUM_PRODS'($urandom);
        if (&r) r[0] = 1'b0;
        return r;
    endfunction

    task automatic start_from_idle();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic accept();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("valid_after_accept", out_valid_o, 0);
        chk("busy_after_accept", busy_o, 0);
    endtask

    task automatic check_result(input int e_sum, input int e_cyc, input int e_sat, input int e_to);
        chk("out_valid", out_valid_o, 1);
        chk("busy_hold", busy_o, 0);
        chk("out_sum", out_sum_o, e_sum);
        chk("out_cycles", out_cycles_o, e_cyc);
        chk("out_sat", out_sat_o, e_sat);
        chk("out_timeout", out_timeout_o, e_to);
    endtask

    // Runs one window from the ARM cycle onward. done_at=0 means never done.
    // done_ts>=0 overrides the popcount on the done cycle; ovr_at pulses start.
    task automatic body(input int done_at, input int ts_mode, input int done_ts,
                        input bit stale, input int ovr_at);
        int tot, ncyc, ts;
        tot = 0;
        ts = pick(ts_mode);
        tree_sum_i  = TREE_W'(ts);
        prod_done_i = stale ? {NUM_PRODS{1'b1}} : not_all();
        tot += ts;
        tick();
        ncyc = (done_at == 0) ? MAXC : done_at;
        for (int k = 1; k <= ncyc; k++) begin
            ts = (k == done_at && done_ts >= 0) ? done_ts : pick(ts_mode);
            tree_sum_i  = TREE_W'(ts);
            prod_done_i = (k == done_at) ? {NUM_PRODS{1'b1}} : not_all();
            start_i     = (k == ovr_at);
            tot += ts;
            tick();
            if (k == 1 && ncyc > 1) begin
                chk("busy_accum", busy_o, 1);
                chk("valid_early", out_valid_o, 0);
            end
        end
        start_i     = 1'b0;
        tree_sum_i  = '0;
        prod_done_i = '0;
        check_result((tot > ACC_MAX) ? ACC_MAX : tot, ncyc,
                     (tot > ACC_MAX) ? 1 : 0, (done_at == 0) ? 1 : 0);
    endtask

    initial begin
        reset_i     = 1'b1;
        start_i     = 1'b0;
        tree_sum_i  = '0;
        prod_done_i = '0;
        out_ready_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        chk("rst_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sum", out_sum_o, 0);
        chk("rst_cycles", out_cycles_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_timeout", out_timeout_o, 0);

        // Basic window: ARM + 5 ACCUM at 16, then done with 0 -> 96 over 6 cycles.
        start_from_idle();
        chk("busy_arm", busy_o, 1);
        body(6, 16, 0, 1'b0, 0);

        // Back-pressure: result must hold while out_ready is low.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid_o, 1);
            chk("bp_sum", out_sum_o, 96);
        end
        out_ready_i = 1'b1;
        start_i     = 1'b1;
        tick();
        out_ready_i = 1'b0;
        start_i     = 1'b0;
        chk("b2b_busy", busy_o, 1);
        chk("b2b_valid", out_valid_o, 0);
        body(3, 2, -1, 1'b0, 0);
        accept();
        chk("no_overrun_b2b", overrun_o, 0);

        // Stale done through start and ARM: closes at the first ACCUM cycle.
        prod_done_i = {NUM_PRODS{1'b1}};
        tree_sum_i  = TREE_W'(4);
        start_from_idle();
        body(1, 4, -1, 1'b1, 0);
        accept();

        // Start during ACCUM: flagged, window unaffected.
        start_from_idle();
        body(10, -1, -1, 1'b0, 4);
        chk("overrun_set", overrun_o, 1);
        accept();

        for (int w = 0; w < 5; w++) begin
            start_from_idle();
            body(int'($urandom_range(1, 50)), -1, -1, 1'b0, 0);
            accept();
        end

        // Saturation, then a start in HOLD without ready is ignored.
        start_from_idle();
        body(300, 16, -1, 1'b0, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("hold_ignore_valid", out_valid_o, 1);
        chk("hold_ignore_sum", out_sum_o, ACC_MAX);
        chk("overrun_sticky", overrun_o, 1);
        accept();

        // Watchdog expiry, then done on the very last permitted cycle.
        start_from_idle();
        body(0, -1, -1, 1'b0, 0);
        accept();
        start_from_idle();
        body(MAXC, 1, -1, 1'b0, 0);
        accept();

        // Reset mid-ACCUM discards the window and clears overrun.
        start_from_idle();
        tree_sum_i = TREE_W'(5);
        tick();
        tick();
        tick();
        chk("pre_reset_busy", busy_o, 1);
        reset_i = 1'b1;
        tick();
        reset_i    = 1'b0;
        tree_sum_i = '0;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_valid", out_valid_o, 0);
        chk("mid_rst_overrun", overrun_o, 0);
        chk("mid_rst_sum", out_sum_o, 0);
        tick();
        chk("idle_stays_valid", out_valid_o, 0);

        start_from_idle();
        body(2, -1, -1, 1'b0, 0);
        accept();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
